mem_bridge: RTL and testbench

- Bridges the CPU native memory bus (valid/ready, 32-bit byte address, 4-bit write strobe) to the word-wide synchronous RAM block (en/write/addr/data_in/data_out, 1-cycle read latency, no byte enables).
- Sits directly upstream of the RAM: decodes the address, sequences reads, and performs read-modify-write for partial-word stores.
- Out-of-range accesses get a zero-data acknowledge.

---
 rtl/mem_bridge_pkg.sv | 16 +
 rtl/mem_byte_merge.sv | 20 ++
 rtl/mem_bridge.sv | 134 +++++++++++++
 tb/tb_mem_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-bus to synchronous-RAM bridge:
// FSM state encoding, strobe width and the full-word strobe constant.
package mem_bridge_pkg;

  localparam int STRB_W = 4;
  localparam logic [STRB_W-1:0] FULL_STRB = 4'hF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    ACK  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational 4-lane byte mux: each lane takes the new byte where its
// strobe is set and keeps the old byte otherwise.
module mem_byte_merge
  import mem_bridge_pkg::*;
(
  input  logic [31:0]       old_word,
  input  logic [31:0]       new_word,
  input  logic [STRB_W-1:0] strb,
  output logic [31:0]       merged
);

  // Select each byte lane independently from its strobe bit.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// CPU native memory bus to word-wide synchronous RAM bridge.
// Handshake: the CPU raises mem_valid and holds it (with address, data and
// strobes) until mem_ready; mem_ready is a single-cycle acknowledge and
// mem_rdata is meaningful only while mem_ready=1. One transaction at a time.
// Reads take RD/RDW (1-cycle RAM latency); partial stores read-modify-write
// through RD/RDW/WR; full stores go straight to WR; out-of-range accesses
// get an immediate zero-data ack and writes to them are dropped.
// Optional macro MEM_BRIDGE_ERR_EN adds sticky err / err_addr outputs that
// record the first out-of-range address seen.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int SIZE  = 14,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             ram_en,
  output logic             ram_write,
  output logic [SIZE-1:0]  ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
`ifdef MEM_BRIDGE_ERR_EN
  ,
  output logic             err,
  output logic [31:0]      err_addr
`endif
);

  if (WIDTH != 32) begin : g_bad_width
    $error("mem_bridge: WIDTH must be 32");
  end

  state_t            state;
  logic [SIZE-1:0]   addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [3:0]        wstrb_q;
  logic [WIDTH-1:0]  merge_q;
  logic [WIDTH-1:0]  rmw_word;
  logic              in_range;
  logic              unused_addr_lsb;

  // Byte offset within a word is irrelevant to a word-wide RAM.
  assign unused_addr_lsb = ^mem_addr[1:0];

  // Only the low SIZE+2 address bits may be non-zero for a RAM hit.
  assign in_range = (mem_addr[31:SIZE+2] == '0);

  mem_byte_merge u_merge (
    .old_word (ram_rdata),
    .new_word (wdata_q),
    .strb     (wstrb_q),
    .merged   (rmw_word)
  );

  // RAM strobes are decoded from state so a reset kills an in-flight write at once.
  always_comb begin
    ram_en    = (state == RD) || (state == WR);
    ram_write = (state == WR);
    ram_addr  = addr_q;
    ram_wdata = (state == WR) ? merge_q : '0;
  end

  // Transaction sequencer with registered ack and load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      merge_q   <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr[SIZE+1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            if (!in_range) begin
              if (mem_wstrb == '0) mem_rdata <= '0;
              mem_ready <= 1'b1;
              state     <= ACK;
            end else if (mem_wstrb == FULL_STRB) begin
              merge_q <= mem_wdata;
              state   <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= RDW;
        RDW: begin
          if (wstrb_q == '0) begin
            mem_rdata <= ram_rdata;
            mem_ready <= 1'b1;
            state     <= ACK;
          end else begin
            merge_q <= rmw_word;
            state   <= WR;
          end
        end
        WR: begin
          mem_ready <= 1'b1;
          state     <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_BRIDGE_ERR_EN
  // Sticky error flag; the address of the first offender is never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (state == IDLE && mem_valid && !in_range) begin
      err <= 1'b1;
      if (!err) err_addr <= mem_addr;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: behavioural RAM, a word-array
// reference model with an expected-read queue, directed cases and a
// randomized transaction mix.
module tb_mem_bridge;

  localparam int SIZE  = 14;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1 << SIZE;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             mem_valid = 1'b0;
  logic             mem_ready;
  logic [31:0]      mem_addr = '0;
  logic [WIDTH-1:0] mem_wdata = '0;
  logic [3:0]       mem_wstrb = '0;
  logic [WIDTH-1:0] mem_rdata;
  logic             ram_en;
  logic             ram_write;
  logic [SIZE-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata = '0;
`ifdef MEM_BRIDGE_ERR_EN
  logic             err;
  logic [31:0]      err_addr;
  logic             exp_err = 1'b0;
  logic [31:0]      exp_err_addr = '0;
`endif

  mem_bridge #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .ram_en    (ram_en),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef MEM_BRIDGE_ERR_EN
    ,
    .err       (err),
    .err_addr  (err_addr)
`endif
  );

  // Behavioural synchronous RAM (registered read, no byte enables)
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_write) ram_mem[ram_addr] <= ram_wdata;
      else           ram_rdata <= ram_mem[ram_addr];
    end
  end

  int ram_en_cnt = 0;
  always @(negedge clk) if (ram_en) ram_en_cnt++;

  // Scoreboard / reference model
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: issue one request, model it, wait for the ack and check it.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    bit oor;
    int exp_lat;
    int n;
    int idx;
    logic [31:0] w;
    oor = ((addr >> (SIZE + 2)) != 0);
    idx = int'((addr >> 2) % DEPTH);
    if (oor) begin
      exp_lat = 1;
      if (wstrb == 4'h0) last_rd = 32'h0;
`ifdef MEM_BRIDGE_ERR_EN
      if (!exp_err) exp_err_addr = addr;
      exp_err = 1'b1;
`endif
    end else if (wstrb == 4'h0) begin
      exp_lat = 3;
      last_rd = ref_mem[idx];
    end else begin
      exp_lat = (wstrb == 4'hF) ? 2 : 4;
      w = ref_mem[idx];
      for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[idx] = w;
    end
    exp_q.push_back(last_rd);

    ram_en_cnt = 0;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && !mem_ready) begin
        // Disturb held inputs: the bridge must work from its latched copies.
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15));
      end
    end while (!mem_ready && n < 20);
    check_eq("latency", 32'(n), 32'(exp_lat));
    check_eq("rdata", mem_rdata, exp_q.pop_front());
    if (oor) check_eq("oor_ram_en", 32'(ram_en_cnt), 32'd0);
`ifdef MEM_BRIDGE_ERR_EN
    check_eq("err", {31'd0, err}, {31'd0, exp_err});
    check_eq("err_addr", err_addr, exp_err_addr);
`endif
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int sel;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    #1;
    check_eq("rst_ready", {31'd0, mem_ready}, 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full write then read
    do_req(32'h0000_0010, 32'hCAFEBABE, 4'hF);
    do_req(32'h0000_0010, 32'h0, 4'h0);
    check_eq("fw_read_const", mem_rdata, 32'hCAFEBABE);

    // Partial write read-modify-write
    do_req(32'h0000_0020, 32'h11223344, 4'hF);
    do_req(32'h0000_0020, 32'hAABBCCDD, 4'b0101);
    check_eq("rdata_held_over_write", mem_rdata, 32'hCAFEBABE);
    do_req(32'h0000_0020, 32'h0, 4'h0);
    check_eq("rmw_const", mem_rdata, 32'h11BB33DD);

    // Out-of-range read, then out-of-range write and in-range read of word 0
    do_req(32'h0000_0000, 32'h7766_5544, 4'hF);
    do_req(32'h0001_0000, 32'h0, 4'h0);
    check_eq("oor_rd_zero", mem_rdata, 32'h0);
    do_req(32'h0002_0000, 32'hFFFF_FFFF, 4'hF);
    do_req(32'h0000_0000, 32'h0, 4'h0);
    check_eq("oor_wr_dropped", mem_rdata, 32'h7766_5544);

    // Back-to-back write/read of word 1
    do_req(32'h0000_0004, 32'h5A5A5A5A, 4'hF);
    do_req(32'h0000_0004, 32'h0, 4'h0);
    check_eq("b2b_const", mem_rdata, 32'h5A5A5A5A);

    // Reset in the middle of a write
    do_req(32'h0000_0040, 32'h0102_0304, 4'hF);
    mem_addr  = 32'h0000_0040;
    mem_wdata = 32'hDEADBEEF;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("wr_active", {30'd0, ram_en, ram_write}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
    check_eq("mid_rst_ram_write", {31'd0, ram_write}, 32'd0);
    check_eq("mid_rst_ram_wdata", ram_wdata, 32'd0);
    check_eq("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("mid_rst_rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_no_ack", {31'd0, mem_ready}, 32'd0);
    check_eq("mid_rst_ram_kept", ram_mem[16], 32'h0102_0304);
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'h0;
`ifdef MEM_BRIDGE_ERR_EN
    exp_err = 1'b0;
    exp_err_addr = 32'h0;
`endif
    do_req(32'h0000_0040, 32'h0, 4'h0);

    // Randomized mix
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (sel == 0) a = 32'h0001_0000 | (32'($urandom_range(0, 255)) << 16);
      case ($urandom_range(0, 2))
        0:       s = 4'h0;
        1:       s = 4'hF;
        default: s = 4'($urandom_range(1, 14));
      endcase
      do_req(a, $urandom, s);
    end
    // Read back every touched word
    for (int i = 0; i < 17; i++) do_req(32'(i) << 2, 32'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
